// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit and the decoder that drives it.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package fetch_unit_pkg;

    localparam int PC_W      = 10;
    localparam int LUT_DEPTH = 16;
    localparam int IDX_W     = 4;
    localparam int PROG_LEN  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Branch codes produced by the decoder.
    localparam logic [1:0] BR_NONE   = 2'b00;
    localparam logic [1:0] BR_IFSC   = 2'b01;
    localparam logic [1:0] BR_IFNSC  = 2'b10;
    localparam logic [1:0] BR_ALWAYS = 2'b11;

    function automatic logic br_taken(input logic [1:0] br, input logic sc);
        case (br)
            BR_IFSC:   return sc;
            BR_IFNSC:  return ~sc;
            BR_ALWAYS: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle between the decoder/control side (master) and the fetch unit (slave).
// Latency: n/a (wires only).
// Backpressure: none; the fetch unit advances every cycle while running.
// Ports: start, branch, target_lut, sc_flag, lut_we/lut_idx/lut_data in;
//        prog_ctr, instr_valid, done out of the fetch unit.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int PC_W = fetch_unit_pkg::PC_W
);
    logic             start;
    logic [1:0]       branch;
    logic [IDX_W-1:0] target_lut;
    logic             sc_flag;
    logic             lut_we;
    logic [IDX_W-1:0] lut_idx;
    logic [PC_W-1:0]  lut_data;
    logic [PC_W-1:0]  prog_ctr;
    logic             instr_valid;
    logic             done;

    modport master (
        output start, branch, target_lut, sc_flag, lut_we, lut_idx, lut_data,
        input  prog_ctr, instr_valid, done
    );

    modport slave (
        input  start, branch, target_lut, sc_flag, lut_we, lut_idx, lut_data,
        output prog_ctr, instr_valid, done
    );
endinterface

// File: rtl/branch_lut.sv
// Branch-target table: LUT_DEPTH x PC_W registers, cleared by reset.
// Latency: read is combinational; a write is visible after the next edge.
// Backpressure: none; writes always accepted when reset is low.
// Ports: clk, reset, we/widx/wdata (sync write), ridx -> rdata (async read).
module branch_lut
    import fetch_unit_pkg::*;
#(
    parameter int PC_W      = fetch_unit_pkg::PC_W,
    parameter int LUT_DEPTH = fetch_unit_pkg::LUT_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [PC_W-1:0]  wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [PC_W-1:0]  rdata
);

    logic [PC_W-1:0] mem [LUT_DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    // Async read sees the pre-write contents during a same-cycle write.
    assign rdata = mem[ridx];

endmodule

// File: rtl/fetch_unit.sv
// Program-counter sequencer: IDLE -> RUN (sequential or LUT-targeted jumps) -> DONE.
// Latency: next address registered one cycle after the branch decision, no bubble.
// Backpressure: none; advances every RUN cycle, start only honoured in IDLE/DONE.
// Ports: clk, reset (sync, active high), bus (fetch_unit_if.slave).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W      = fetch_unit_pkg::PC_W,
    parameter int LUT_DEPTH = fetch_unit_pkg::LUT_DEPTH,
    parameter int PROG_LEN  = fetch_unit_pkg::PROG_LEN
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.slave   bus
);

    // One extra bit so PROG_LEN == 2**PC_W is representable.
    localparam logic [PC_W:0]   PROG_END  = (PC_W+1)'(PROG_LEN);
    localparam logic [PC_W-1:0] PROG_LAST = PC_W'(PROG_LEN - 1);

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic            vld_q;
    logic            done_q;
    logic [PC_W-1:0] tgt;
    logic            taken;

    branch_lut #(
        .PC_W      (PC_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_lut (
        .clk   (clk),
        .reset (reset),
        .we    (bus.lut_we),
        .widx  (bus.lut_idx),
        .wdata (bus.lut_data),
        .ridx  (bus.target_lut),
        .rdata (tgt)
    );

    assign taken = br_taken(bus.branch, bus.sc_flag);

    // instr_valid/done are loaded alongside the state so they always equal
    // a decode of the registered state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            pc_q   <= '0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state  <= ST_RUN;
                        pc_q   <= '0;
                        vld_q  <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (taken) begin
                        pc_q <= tgt;
                        // Out-of-range target ends the program; an in-range
                        // target equal to the current pc is a legal spin.
                        if ({1'b0, tgt} >= PROG_END) begin
                            state  <= ST_DONE;
                            vld_q  <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end else if (pc_q == PROG_LAST) begin
                        // Fall off the end: hold the last address, no wrap.
                        state  <= ST_DONE;
                        vld_q  <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        pc_q <= pc_q + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    pc_q   <= '0;
                    vld_q  <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prog_ctr    = pc_q;
    assign bus.instr_valid = vld_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, monitors pop and compare.
// Two instances: PROG_LEN=512 for branch/LUT/reset cases, PROG_LEN=16 for end-of-program.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    fetch_unit_if #(.PC_W(10)) ia ();
    fetch_unit_if #(.PC_W(10)) ib ();

    fetch_unit #(.PC_W(10), .LUT_DEPTH(16), .PROG_LEN(512)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ia.slave)
    );

    fetch_unit #(.PC_W(10), .LUT_DEPTH(16), .PROG_LEN(16)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ib.slave)
    );

    typedef struct packed {
        logic [9:0]  pc;
        logic        v;
        logic        d;
        logic [15:0] tag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   tag_a  = 0;
    int   tag_b  = 0;

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, tag, act, exp);
        end
    endtask

    // Monitors: compare one expectation per cycle, away from the active edge.
    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk("a_pc",    int'(ea.tag), 32'(ia.prog_ctr),    32'(ea.pc));
            chk("a_valid", int'(ea.tag), 32'(ia.instr_valid), 32'(ea.v));
            chk("a_done",  int'(ea.tag), 32'(ia.done),        32'(ea.d));
        end
    end

    always @(negedge clk) begin
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk("b_pc",    int'(eb.tag), 32'(ib.prog_ctr),    32'(eb.pc));
            chk("b_valid", int'(eb.tag), 32'(ib.instr_valid), 32'(eb.v));
            chk("b_done",  int'(eb.tag), 32'(ib.done),        32'(eb.d));
        end
    end

    // Drive one cycle of inputs on instance A, then queue the expected post-edge outputs.
    task automatic sa(input logic st, input logic [1:0] br, input logic [3:0] ti, input logic sc,
                      input logic we, input logic [3:0] wi, input logic [9:0] wd,
                      input logic [9:0] pc, input logic v, input logic d);
        exp_t e;
        ia.start      = st;
        ia.branch     = br;
        ia.target_lut = ti;
        ia.sc_flag    = sc;
        ia.lut_we     = we;
        ia.lut_idx    = wi;
        ia.lut_data   = wd;
        @(posedge clk);
        #1;
        e.pc  = pc;
        e.v   = v;
        e.d   = d;
        e.tag = 16'(tag_a);
        qa.push_back(e);
        tag_a++;
    endtask

    task automatic sb(input logic st, input logic [9:0] pc, input logic v, input logic d);
        exp_t e;
        ib.start = st;
        @(posedge clk);
        #1;
        e.pc  = pc;
        e.v   = v;
        e.d   = d;
        e.tag = 16'(tag_b);
        qb.push_back(e);
        tag_b++;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ib.start = 1'b0; ib.branch = BR_NONE; ib.target_lut = '0; ib.sc_flag = 1'b0;
        ib.lut_we = 1'b0; ib.lut_idx = '0; ib.lut_data = '0;

        // ---- Instance A (PROG_LEN=512) ----
        sa(0, BR_NONE, 0, 0, 0, 0, 0,    0, 0, 0);           // reset state
        sa(1, BR_NONE, 0, 0, 1, 3, 55,   0, 0, 0);           // reset beats start and lut_we
        rst_a = 1'b0;
        sa(0, BR_ALWAYS, 3, 1, 1, 3, 40, 0, 0, 0);           // branch ignored in IDLE; LUT[3]=40
        sa(0, BR_NONE, 0, 0, 1, 2, 20,   0, 0, 0);           // LUT[2]=20
        sa(0, BR_NONE, 0, 0, 1, 7, 7,    0, 0, 0);           // LUT[7]=7
        sa(0, BR_NONE, 0, 0, 1, 6, 42,   0, 0, 0);           // LUT[6]=42
        sa(0, BR_NONE, 0, 0, 1, 8, 10,   0, 0, 0);           // LUT[8]=10
        sa(1, BR_NONE, 0, 0, 0, 0, 0,    0, 1, 0);           // start -> RUN at 0
        for (int i = 1; i <= 7; i++)
            sa(0, BR_NONE, 0, 0, 0, 0, 0, 10'(i), 1, 0);     // sequential 1..7
        sa(0, BR_IFSC,   3, 1, 0, 0, 0, 40, 1, 0);           // jump if sc, sc=1
        sa(0, BR_ALWAYS, 7, 0, 0, 0, 0,  7, 1, 0);           // back to 7
        sa(0, BR_IFSC,   3, 0, 0, 0, 0,  8, 1, 0);           // jump if sc, sc=0 -> fall through
        sa(0, BR_ALWAYS, 7, 1, 0, 0, 0,  7, 1, 0);
        sa(0, BR_IFNSC,  3, 0, 0, 0, 0, 40, 1, 0);           // jump if !sc, sc=0
        sa(0, BR_IFNSC,  3, 1, 0, 0, 0, 41, 1, 0);           // jump if !sc, sc=1 -> fall through
        sa(1, BR_NONE,   0, 0, 0, 0, 0, 42, 1, 0);           // start ignored in RUN
        sa(0, BR_ALWAYS, 6, 0, 0, 0, 0, 42, 1, 0);           // spin on own address
        sa(0, BR_ALWAYS, 6, 0, 0, 0, 0, 42, 1, 0);
        sa(0, BR_ALWAYS, 2, 0, 1, 2, 99, 20, 1, 0);          // same-cycle write: old value
        sa(0, BR_ALWAYS, 2, 0, 0, 0, 0, 99, 1, 0);           // new value afterwards
        sa(0, BR_ALWAYS, 8, 0, 0, 0, 0, 10, 1, 0);
        sa(0, BR_NONE,   0, 0, 0, 0, 0, 11, 1, 0);
        sa(0, BR_NONE,   0, 0, 0, 0, 0, 12, 1, 0);
        rst_a = 1'b1;
        sa(1, BR_ALWAYS, 3, 0, 1, 4, 77, 0, 0, 0);           // reset mid-RUN at 12
        rst_a = 1'b0;
        sa(0, BR_ALWAYS, 3, 0, 0, 0, 0,  0, 0, 0);           // IDLE holds
        sa(1, BR_NONE,   0, 0, 0, 0, 0,  0, 1, 0);
        sa(0, BR_ALWAYS, 3, 0, 0, 0, 0,  0, 1, 0);           // LUT cleared
        sa(0, BR_ALWAYS, 4, 0, 0, 0, 0,  0, 1, 0);           // write during reset dropped
        sa(0, BR_NONE,   0, 0, 1, 5, 1023, 1, 1, 0);         // LUT write while running
        sa(0, BR_ALWAYS, 5, 0, 0, 0, 0, 1023, 0, 1);         // out-of-range target -> DONE
        sa(0, BR_ALWAYS, 3, 0, 0, 0, 0, 1023, 0, 1);         // DONE holds, branch ignored
        sa(1, BR_NONE,   0, 0, 0, 0, 0,  0, 1, 0);           // restart from DONE
        sa(0, BR_NONE,   0, 0, 0, 0, 0,  1, 1, 0);

        // ---- Instance B (PROG_LEN=16) ----
        sb(0, 0, 0, 0);
        rst_b = 1'b0;
        sb(1, 0, 1, 0);
        for (int i = 1; i <= 15; i++)
            sb(0, 10'(i), 1, 0);
        sb(0, 15, 0, 1);                                     // end of program, no wrap
        sb(0, 15, 0, 1);
        sb(1, 0, 1, 0);
        sb(0, 1, 1, 0);

        repeat (3) @(negedge clk);
        #1;
        chk("a_drain", 0, 32'(qa.size()), 32'd0);
        chk("b_drain", 0, 32'(qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
